// File: rtl/fft_pkg.sv
// Constants shared by the 16-point FFT core, its twiddle ROM and the frame loader.
package fft_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_ADDR_W = 4;
  localparam int FFT_DATA_W = 16;
  localparam int F_POINT    = 14;

  localparam logic [FFT_ADDR_W-1:0] FFT_LAST_IDX = FFT_ADDR_W'(FFT_N - 1);

  // Occupancy of the two-bank ping-pong buffer: 0, 1 or 2 full frames.
  typedef logic [1:0] fill_t;

  localparam fill_t FILL_EMPTY = 2'd0;
  localparam fill_t FILL_FULL  = 2'd2;

  function automatic fill_t next_fill(input fill_t fill, input logic complete,
                                      input logic deliver);
    fill_t nxt;
    nxt = fill;
    case ({complete, deliver})
      2'b10:   nxt = fill + 2'd1;
      2'b01:   nxt = fill - 2'd1;
      default: nxt = fill;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of N complex samples: addressed single-sample write, full parallel read-out.
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_W,
  parameter int N          = FFT_N
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [FFT_ADDR_W-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wr_r,
  input  logic [DATA_WIDTH-1:0]   wr_i,
  output logic [N*DATA_WIDTH-1:0] rd_r,
  output logic [N*DATA_WIDTH-1:0] rd_i
);

  logic [DATA_WIDTH-1:0] mem_r [N];
  logic [DATA_WIDTH-1:0] mem_i [N];

  // NOTE: sample storage has no reset; its contents are only observed once a
  // frame has been fully written, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wr_r;
      mem_i[addr] <= wr_i;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign rd_r[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[k];
    assign rd_i[k*DATA_WIDTH +: DATA_WIDTH] = mem_i[k];
  end

endmodule

// File: rtl/fft_16_frame_loader.sv
// Serial-to-parallel ping-pong frame loader feeding the 16-point combinational FFT core.
module fft_16_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_W,
  parameter int N          = FFT_N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic [DATA_WIDTH-1:0]   in_r,
  input  logic [DATA_WIDTH-1:0]   in_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*DATA_WIDTH-1:0] out_r,
  output logic [N*DATA_WIDTH-1:0] out_i,
  output logic                    err_sof,
  output logic [7:0]              frame_cnt
);

  if (N != FFT_N) begin : g_bad_n
    $error("fft_16_frame_loader supports only N == 16");
  end

  logic [FFT_ADDR_W-1:0] wr_idx;
  logic                  wr_bank;
  logic                  rd_bank;
  fill_t                 full_cnt;
  fill_t                 full_next;

  logic                  accept;
  logic                  deliver;
  logic                  complete;
  logic [FFT_ADDR_W-1:0] idx;

  logic [N*DATA_WIDTH-1:0] bank_r [2];
  logic [N*DATA_WIDTH-1:0] bank_i [2];

  // Ready depends on registered occupancy only, so no combinational path
  // from out_ready back to in_ready.
  assign in_ready  = (full_cnt != FILL_FULL);
  assign out_valid = (full_cnt != FILL_EMPTY);
  assign accept    = in_valid & in_ready;
  assign deliver   = out_valid & out_ready;
  assign idx       = in_sof ? '0 : wr_idx;
  assign complete  = accept & (idx == FFT_LAST_IDX);
  assign out_r     = bank_r[rd_bank];
  assign out_i     = bank_i[rd_bank];

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    full_next = full_cnt;
    full_next = next_fill(full_cnt, complete, deliver);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_frame_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .N         (N)
    ) u_bank (
      .clk (clk),
      .we  (accept && (wr_bank == 1'(b))),
      .addr(idx),
      .wr_r(in_r),
      .wr_i(in_i),
      .rd_r(bank_r[b]),
      .rd_i(bank_i[b])
    );
  end

  // NOTE: state registers use non-blocking assignments so every update in
  // this block sees the pre-edge values, matching flip-flop behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full_cnt  <= FILL_EMPTY;
      err_sof   <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      err_sof  <= accept & in_sof & (wr_idx != '0);
      full_cnt <= full_next;
      if (accept) begin
        wr_idx <= idx + 1'b1;
      end
      if (complete) begin
        wr_bank <= ~wr_bank;
      end
      if (deliver) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_16_frame_loader.sv
// Directed and scoreboarded bench for the 16-sample ping-pong frame loader.
module tb_fft_16_frame_loader;

  localparam int DW = 16;
  localparam int NP = 16;
  localparam int SOAK_FRAMES = 640;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_sof;
  logic [DW-1:0]   in_r;
  logic [DW-1:0]   in_i;
  logic            out_valid;
  logic            out_ready;
  logic [NP*DW-1:0] out_r;
  logic [NP*DW-1:0] out_i;
  logic            err_sof;
  logic [7:0]      frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_16_frame_loader #(.DATA_WIDTH(DW), .N(NP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sof   (in_sof),
    .in_r     (in_r),
    .in_i     (in_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_i    (out_i),
    .err_sof  (err_sof),
    .frame_cnt(frame_cnt)
  );

  // Expected frame of ramp samples base..base+15.
  function automatic logic [NP*DW-1:0] mk_r(input int base);
    logic [NP*DW-1:0] v;
    for (int k = 0; k < NP; k++) v[k*DW +: DW] = 16'(base + k);
    return v;
  endfunction

  // Imaginary part: negated ramp, or bitwise-inverted ramp for the soak.
  function automatic logic [NP*DW-1:0] mk_i(input int base, input bit inv);
    logic [NP*DW-1:0] v;
    for (int k = 0; k < NP; k++)
      v[k*DW +: DW] = inv ? ~16'(base + k) : 16'(-(base + k));
    return v;
  endfunction

  task automatic apply_reset();
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_r      = '0;
    in_i      = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push(input int v, input bit sof);
    int n;
    in_valid = 1'b1;
    in_r     = 16'(v);
    in_i     = 16'(-v);
    in_sof   = sof;
    n = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_timeout: sample %0d in_ready=%b, required 1", v, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 0; in_sof = 0; in_r = '0; in_i = '0; out_ready = 0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (err_sof !== 1'b0) begin errors++; $display("FAIL rst_err_sof: got %b want 0", err_sof); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d want 0", frame_cnt); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    apply_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) push(k, k == 0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: got %b want 0", out_valid); end
    @(posedge clk); #1;
    push(15, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid: got %b want 1", out_valid); end
    checks++; if (out_r[5*DW +: DW] !== 16'd5) begin errors++; $display("FAIL t1_x5_r: got %h want 0005", out_r[5*DW +: DW]); end
    checks++; if (out_i[5*DW +: DW] !== 16'hFFFB) begin errors++; $display("FAIL t1_x5_i: got %h want fffb", out_i[5*DW +: DW]); end
    checks++; if (out_r !== mk_r(0)) begin errors++; $display("FAIL t1_frame_r: got %h want %h", out_r, mk_r(0)); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL t1_cnt_before: got %0d want 0", frame_cnt); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop: got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL t1_cnt: got %0d want 1", frame_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_pressure();
    apply_reset();
    for (int s = 0; s < 32; s++) push(s, (s % 16) == 0);
    in_valid = 1'b1; in_r = 16'd32; in_i = 16'(-32); in_sof = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL t2_in_ready_%0d: got %b want 0", c, in_ready); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t2_valid_%0d: got %b want 1", c, out_valid); end
      checks++; if (out_r !== mk_r(0)) begin errors++; $display("FAIL t2_hold_r_%0d: got %h want %h", c, out_r, mk_r(0)); end
      checks++; if (out_i !== mk_i(0, 0)) begin errors++; $display("FAIL t2_hold_i_%0d: got %h want %h", c, out_i, mk_i(0, 0)); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_r !== mk_r(0)) begin errors++; $display("FAIL t2_frame_a: got %h want %h", out_r, mk_r(0)); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t2_ready_rise: got %b want 1", in_ready); end
    checks++; if (out_r !== mk_r(16)) begin errors++; $display("FAIL t2_frame_b_r: got %h want %h", out_r, mk_r(16)); end
    checks++; if (out_i !== mk_i(16, 0)) begin errors++; $display("FAIL t2_frame_b_i: got %h want %h", out_i, mk_i(16, 0)); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL t2_cnt: got %0d want 1", frame_cnt); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int s = 33; s < 40; s++) push(s, 1'b0);
    @(negedge clk);
    checks++; if (out_r !== mk_r(16)) begin errors++; $display("FAIL t2_b_stable: got %h want %h", out_r, mk_r(16)); end
    @(posedge clk); #1;
  endtask

  task automatic test_concurrent();
    apply_reset();
    for (int s = 0; s < 31; s++) push(s, (s % 16) == 0);
    in_valid = 1'b1; in_r = 16'd31; in_i = 16'(-31); out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_ready: got %b want 1", in_ready); end
    checks++; if (out_r !== mk_r(0)) begin errors++; $display("FAIL t3_first: got %h want %h", out_r, mk_r(0)); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t3_valid: got %b want 1", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t3_fill_one: in_ready got %b want 1", in_ready); end
    checks++; if (out_r !== mk_r(16)) begin errors++; $display("FAIL t3_next_r: got %h want %h", out_r, mk_r(16)); end
    checks++; if (out_i !== mk_i(16, 0)) begin errors++; $display("FAIL t3_next_i: got %h want %h", out_i, mk_i(16, 0)); end
    checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL t3_cnt: got %0d want 1", frame_cnt); end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_drain: out_valid got %b want 0", out_valid); end
    checks++; if (frame_cnt !== 8'd2) begin errors++; $display("FAIL t3_cnt2: got %0d want 2", frame_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_realign();
    apply_reset();
    push(1, 1'b1);
    @(negedge clk);
    checks++; if (err_sof !== 1'b0) begin errors++; $display("FAIL t4_legal_sof: err_sof got %b want 0", err_sof); end
    @(posedge clk); #1;
    for (int s = 2; s <= 7; s++) push(s, 1'b0);
    push(100, 1'b1);
    @(negedge clk);
    checks++; if (err_sof !== 1'b1) begin errors++; $display("FAIL t4_err_pulse: got %b want 1", err_sof); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (err_sof !== 1'b0) begin errors++; $display("FAIL t4_err_once: got %b want 0", err_sof); end
    @(posedge clk); #1;
    for (int s = 101; s <= 115; s++) push(s, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b want 1", out_valid); end
    checks++; if (out_r[DW-1:0] !== 16'd100) begin errors++; $display("FAIL t4_x0_r: got %0d want 100", out_r[DW-1:0]); end
    checks++; if (out_r !== mk_r(100)) begin errors++; $display("FAIL t4_frame_r: got %h want %h", out_r, mk_r(100)); end
    checks++; if (out_i !== mk_i(100, 0)) begin errors++; $display("FAIL t4_frame_i: got %h want %h", out_i, mk_i(100, 0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    for (int s = 0; s < 21; s++) push(s, (s % 16) == 0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid_async: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_async: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL t5_ready_release: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t5_valid_release: got %b want 0", out_valid); end
    @(posedge clk); #1;
    for (int s = 200; s < 216; s++) push(s, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t5_valid: got %b want 1", out_valid); end
    checks++; if (out_r !== mk_r(200)) begin errors++; $display("FAIL t5_frame_r: got %h want %h", out_r, mk_r(200)); end
    checks++; if (out_i !== mk_i(200, 0)) begin errors++; $display("FAIL t5_frame_i: got %h want %h", out_i, mk_i(200, 0)); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL t5_cnt: got %0d want 0", frame_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_soak();
    int   s         = 0;
    int   delivered = 0;
    int   cyc       = 0;
    int   err_seen  = 0;
    int   q[$];
    logic [7:0] exp_cnt = 8'd0;
    bit   acc, del;
    apply_reset();
    while (delivered < SOAK_FRAMES && cyc < 60000) begin
      in_valid  = (s < SOAK_FRAMES * NP) && ($urandom_range(9) < 7);
      in_r      = 16'(s);
      in_i      = ~16'(s);
      in_sof    = ((s % NP) == 0);
      out_ready = ($urandom_range(9) < 6);
      @(negedge clk);
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL soak_valid: cyc %0d got %b want %b", cyc, out_valid, q.size() != 0); end
      checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL soak_ready: cyc %0d got %b want %b", cyc, in_ready, q.size() < 2); end
      if (err_sof === 1'b1) err_seen++;
      acc = in_valid && (q.size() < 2);
      del = out_ready && (q.size() != 0);
      if (del) begin
        checks++; if (out_r !== mk_r(q[0])) begin errors++; $display("FAIL soak_frame_r: frame %0d got %h want %h", delivered, out_r, mk_r(q[0])); end
        checks++; if (out_i !== mk_i(q[0], 1)) begin errors++; $display("FAIL soak_frame_i: frame %0d got %h want %h", delivered, out_i, mk_i(q[0], 1)); end
        checks++; if (frame_cnt !== exp_cnt) begin errors++; $display("FAIL soak_cnt: frame %0d got %0d want %0d", delivered, frame_cnt, exp_cnt); end
        void'(q.pop_front());
        exp_cnt++;
        delivered++;
      end
      if (acc) begin
        s++;
        if ((s % NP) == 0) q.push_back(s - NP);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (delivered != SOAK_FRAMES) begin errors++; $display("FAIL soak_timeout: delivered %0d want %0d", delivered, SOAK_FRAMES); end
    checks++; if (frame_cnt !== 8'(SOAK_FRAMES)) begin errors++; $display("FAIL soak_wrap: frame_cnt got %0d want %0d", frame_cnt, 8'(SOAK_FRAMES)); end
    checks++; if (err_seen != 0) begin errors++; $display("FAIL soak_err_sof: got %0d pulses want 0", err_seen); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_pressure();
    test_concurrent();
    test_realign();
    test_async_reset();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
